// File: rtl/lsu_align.sv
// lsu_align: load/store alignment unit. Takes one right-aligned load/store
// request, issues a single lane-positioned memory access, then returns the
// extended load data (or an error pulse for misaligned/oversized requests).
module lsu_align #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_sign,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W/8-1:0]   mem_be,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_data,
  output logic                  rsp_err
);
  localparam int NB = DATA_W / 8;
  localparam int OB = $clog2(NB);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MEM  = 2'd1;
  localparam logic [1:0] S_RSP  = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  logic [1:0]        r_state;
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_sign;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;

  int                w_req_bytes;
  int                w_req_off;
  logic              w_req_err;
  int                w_bytes;
  int                w_off;
  logic [NB-1:0]     w_be;
  logic [DATA_W-1:0] w_wmask;
  logic [DATA_W-1:0] w_wd;
  logic [DATA_W-1:0] w_sh;
  logic              w_top;
  logic [DATA_W-1:0] w_ext;
  logic              w_mem;

  // Legality of the incoming request: size must fit the bus and the
  // offset must be naturally aligned to the access size.
  always_comb begin
    w_req_bytes = 1 << req_size;
    w_req_off   = int'(req_addr[OB-1:0]);
    w_req_err   = (w_req_bytes > NB) || ((w_req_off & (w_req_bytes - 1)) != 0);
  end

  // Lane steering for the captured request: byte enables, store data
  // placement and load field extraction with sign/zero extension.
  always_comb begin
    w_bytes = 1 << r_size;
    w_off   = int'(r_addr[OB-1:0]);
    for (int i = 0; i < NB; i++) begin
      w_be[i]            = (i >= w_off) && (i < w_off + w_bytes);
      w_wmask[8*i +: 8]  = (i < w_bytes) ? 8'hFF : 8'h00;
    end
    w_wd = (r_wdata & w_wmask) << (8 * w_off);
    w_sh = mem_rdata >> (8 * w_off);
    case (r_size)
      2'd0:    w_top = w_sh[7];
      2'd1:    w_top = w_sh[15];
      2'd2:    w_top = w_sh[31];
      default: w_top = w_sh[DATA_W-1];
    endcase
    for (int i = 0; i < DATA_W; i++)
      w_ext[i] = (i < 8 * w_bytes) ? w_sh[i] : (r_sign & w_top);
  end

  // Outputs are decoded from state so reset clears them immediately.
  assign w_mem     = (r_state == S_MEM);
  assign req_ready = (r_state == S_IDLE);
  assign mem_req   = w_mem;
  assign mem_we    = w_mem & r_we;
  assign mem_addr  = w_mem ? {r_addr[ADDR_W-1:OB], {OB{1'b0}}} : '0;
  assign mem_be    = w_mem ? w_be : '0;
  assign mem_wdata = (w_mem && r_we) ? w_wd : '0;
  assign rsp_valid = (r_state == S_RSP) || (r_state == S_ERR);
  assign rsp_err   = (r_state == S_ERR);
  assign rsp_data  = (r_state == S_RSP) ? r_rdata : '0;

  // Control FSM: accept in IDLE, hold the access until ack, one-cycle response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_size  <= 2'd0;
      r_sign  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_we    <= req_we;
          r_size  <= req_size;
          r_sign  <= req_sign;
          r_addr  <= req_addr;
          r_wdata <= req_wdata;
          r_state <= w_req_err ? S_ERR : S_MEM;
        end
        S_MEM: if (mem_ack) begin
          r_rdata <= r_we ? '0 : w_ext;
          r_state <= S_RSP;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_align.sv
// tb_lsu_align: directed vectors with hand-computed expectations for the
// 32-bit unit, plus a 64-bit instance for the dword cases.
module tb_lsu_align;
  logic        clk = 1'b0;
  logic        reset;
  // 32-bit instance
  logic        req_valid, req_ready, req_we, req_sign;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_data;
  // 64-bit instance
  logic        q_valid, q_ready, q_we, q_sign;
  logic [1:0]  q_size;
  logic [31:0] q_addr;
  logic [63:0] q_wdata;
  logic        m_req, m_we, m_ack;
  logic [31:0] m_addr;
  logic [63:0] m_wdata, m_rdata;
  logic [7:0]  m_be;
  logic        r_valid, r_err;
  logic [63:0] r_data;

  int n_chk = 0;
  int n_err = 0;
  int rsp_cnt = 0;

  always #5 clk = ~clk;

  lsu_align #(.DATA_W(32), .ADDR_W(32)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_sign(req_sign), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  lsu_align #(.DATA_W(64), .ADDR_W(32)) u_dut64 (
    .clk(clk), .reset(reset),
    .req_valid(q_valid), .req_ready(q_ready), .req_we(q_we),
    .req_size(q_size), .req_sign(q_sign), .req_addr(q_addr),
    .req_wdata(q_wdata),
    .mem_req(m_req), .mem_we(m_we), .mem_addr(m_addr), .mem_be(m_be),
    .mem_wdata(m_wdata), .mem_ack(m_ack), .mem_rdata(m_rdata),
    .rsp_valid(r_valid), .rsp_data(r_data), .rsp_err(r_err)
  );

  // Count response pulses of the 32-bit unit, sampled mid-cycle.
  always @(negedge clk) if (rsp_valid) rsp_cnt <= rsp_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [1:0] size, input logic sign,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_valid = 1'b1;
    req_we    = we;
    req_size  = size;
    req_sign  = sign;
    req_addr  = addr;
    req_wdata = wdata;
  endtask

  initial begin
    int base;
    reset = 1'b1;
    req_valid = 0; req_we = 0; req_size = 0; req_sign = 0; req_addr = 0; req_wdata = 0;
    mem_ack = 0; mem_rdata = 0;
    q_valid = 0; q_we = 0; q_size = 0; q_sign = 0; q_addr = 0; q_wdata = 0;
    m_ack = 0; m_rdata = 0;
    #12;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_mem_be", mem_be, 0);
    @(posedge clk); #1 reset = 1'b0;
    chk("rst_ready", req_ready, 1);

    // signed lb at 0x1003
    drive(0, 2'd0, 1, 32'h1003, 32'h0);
    tick();
    req_valid = 0;
    chk("lb_mem_req", mem_req, 1);
    chk("lb_ready", req_ready, 0);
    chk("lb_addr", mem_addr, 32'h1000);
    chk("lb_be", mem_be, 4'b1000);
    chk("lb_we", mem_we, 0);
    chk("lb_wdata", mem_wdata, 0);
    mem_ack = 1; mem_rdata = 32'hA5123456;
    tick();
    mem_ack = 0;
    chk("lb_rsp_valid", rsp_valid, 1);
    chk("lb_rsp_data", rsp_data, 32'hFFFFFFA5);
    chk("lb_rsp_err", rsp_err, 0);
    chk("lb_mem_req_off", mem_req, 0);
    tick();
    chk("lb_rsp_clr", rsp_valid, 0);
    chk("lb_data_clr", rsp_data, 0);
    chk("lb_ready_back", req_ready, 1);

    // unsigned lh, ack three cycles late
    drive(0, 2'd1, 0, 32'h2002, 32'h0);
    tick();
    req_valid = 0;
    mem_rdata = 32'h80011234;
    for (int k = 0; k < 4; k++) begin
      chk("lh_hold_req", mem_req, 1);
      chk("lh_hold_addr", mem_addr, 32'h2000);
      chk("lh_hold_be", mem_be, 4'b1100);
      chk("lh_no_rsp", rsp_valid, 0);
      if (k == 3) mem_ack = 1;
      tick();
    end
    mem_ack = 0;
    chk("lh_rsp_valid", rsp_valid, 1);
    chk("lh_rsp_data", rsp_data, 32'h00008001);
    tick();

    // sh at 0x2002
    drive(1, 2'd1, 0, 32'h2002, 32'h0000BEEF);
    tick();
    req_valid = 0;
    chk("sh_we", mem_we, 1);
    chk("sh_be", mem_be, 4'b1100);
    chk("sh_wdata", mem_wdata, 32'hBEEF0000);
    mem_ack = 1;
    tick();
    mem_ack = 0;
    chk("sh_rsp_valid", rsp_valid, 1);
    chk("sh_rsp_data", rsp_data, 0);
    tick();

    // misaligned lw
    drive(0, 2'd2, 0, 32'h1001, 32'h0);
    tick();
    req_valid = 0;
    chk("mis_mem_req", mem_req, 0);
    chk("mis_rsp_valid", rsp_valid, 1);
    chk("mis_rsp_err", rsp_err, 1);
    chk("mis_rsp_data", rsp_data, 0);
    tick();
    chk("mis_ready", req_ready, 1);
    chk("mis_err_clr", rsp_err, 0);

    // dword on 32-bit bus
    drive(0, 2'd3, 0, 32'h0, 32'h0);
    tick();
    req_valid = 0;
    chk("dw32_mem_req", mem_req, 0);
    chk("dw32_err", rsp_err, 1);
    tick();

    // 64-bit: ld at 0x8, then signed lw at 0xC
    q_valid = 1; q_we = 0; q_size = 2'd3; q_sign = 1; q_addr = 32'h8;
    tick();
    q_valid = 0;
    chk("ld64_req", m_req, 1);
    chk("ld64_be", m_be, 8'hFF);
    chk("ld64_addr", m_addr, 32'h8);
    m_ack = 1; m_rdata = 64'h8000_0000_0000_0001;
    tick();
    m_ack = 0;
    chk("ld64_err", r_err, 0);
    chk("ld64_data", r_data, 64'h8000_0000_0000_0001);
    tick();
    q_valid = 1; q_size = 2'd2; q_sign = 1; q_addr = 32'hC;
    tick();
    q_valid = 0;
    chk("lw64_be", m_be, 8'hF0);
    chk("lw64_addr", m_addr, 32'h8);
    m_ack = 1; m_rdata = 64'h89AB_CDEF_0000_0000;
    tick();
    m_ack = 0;
    chk("lw64_data", r_data, 64'hFFFF_FFFF_89AB_CDEF);
    tick();

    // reset while waiting in MEM
    base = rsp_cnt;
    drive(0, 2'd2, 0, 32'h4000, 32'h0);
    tick();
    req_valid = 0;
    chk("rm_mem_req", mem_req, 1);
    #2 reset = 1'b1;
    #1;
    chk("rm_async_req", mem_req, 0);
    chk("rm_async_addr", mem_addr, 0);
    tick();
    reset = 1'b0;
    mem_ack = 1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_ack = 0;
    tick();
    chk("rm_no_rsp", rsp_cnt - base, 0);
    chk("rm_ready", req_ready, 1);
    drive(0, 2'd2, 0, 32'h4004, 32'h0);
    tick();
    req_valid = 0;
    chk("rm_next_addr", mem_addr, 32'h4004);
    mem_ack = 1; mem_rdata = 32'h0BADF00D;
    tick();
    mem_ack = 0;
    chk("rm_next_data", rsp_data, 32'h0BADF00D);
    tick();

    // back-to-back loads with req_valid held high
    base = rsp_cnt;
    for (int k = 0; k < 3; k++) begin
      logic [31:0] a, rd, ex;
      logic [3:0]  be;
      logic [1:0]  sz;
      logic        sg;
      case (k)
        0: begin a = 32'h3000; sz = 2'd0; sg = 0; rd = 32'h000000F0; ex = 32'h000000F0; be = 4'b0001; end
        1: begin a = 32'h3002; sz = 2'd1; sg = 1; rd = 32'hFFEE0000; ex = 32'hFFFFFFEE; be = 4'b1100; end
        default: begin a = 32'h3004; sz = 2'd2; sg = 0; rd = 32'h12345678; ex = 32'h12345678; be = 4'b1111; end
      endcase
      drive(0, sz, sg, a, 32'h0);
      tick();
      chk("b2b_addr", mem_addr, {a[31:2], 2'b00});
      chk("b2b_be", mem_be, be);
      mem_ack = 1; mem_rdata = rd;
      tick();
      mem_ack = 0;
      chk("b2b_rsp_valid", rsp_valid, 1);
      chk("b2b_rsp_data", rsp_data, ex);
      chk("b2b_ready_rsp", req_ready, 0);
      tick();
      chk("b2b_ready_idle", req_ready, 1);
      chk("b2b_no_req_idle", mem_req, 0);
    end
    req_valid = 0;
    tick();
    chk("b2b_count", rsp_cnt - base, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
